vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, clocks per line.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, lines per frame.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, clocks of hsync-high per line.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, lines of vsync-high per frame.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, consecutive clean frames required for lock.
REQ-006 SHALL have port clock  in  1  pixel clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port hsync  in  1  high during active columns, low elsewhere.
REQ-009 SHALL have port vsync  in  1  high during active rows, low elsewhere.
REQ-010 SHALL have port col  out  $clog2(TOTAL_COLS)  recovered column index.
REQ-011 SHALL have port row  out  $clog2(TOTAL_ROWS)  recovered row index.
REQ-012 SHALL have port frame_start  out  1  one-cycle pulse at row 0, col 0.
REQ-013 SHALL have port locked  out  1  high while timing matches parameters.
REQ-014 SHALL have port sync_err  out  1  one-cycle pulse on any timing violation.

Function
REQ-015 SHALL register hsync/vsync once; rise = registered high and previous registered value low.
REQ-016 SHALL drive col=0 in the cycle the hsync rise is detected; latency input-to-col is 1 clock.
REQ-017 SHALL increment col by 1 each clock otherwise, wrapping TOTAL_COLS-1 -> 0 (freewheel).
REQ-018 SHALL increment row by 1 on each hsync rise, wrapping TOTAL_ROWS-1 -> 0; vsync rise coincident with hsync rise forces row=0.
REQ-019 SHALL flag line error: hsync rise with col != TOTAL_COLS-1, or col == TOTAL_COLS-1 with no rise next cycle, or hsync fall with col != ACTIVE_COLS-1.
REQ-020 SHALL flag frame error: vsync rise with row != TOTAL_ROWS-1, vsync rise without coincident hsync rise, or vsync fall with row != ACTIVE_ROWS.
REQ-021 SHALL implement FSM SEARCH -> ALIGN -> LOCKED.
REQ-022 SEARCH: ignore errors; first vsync rise -> ALIGN, clear clean-frame count.
REQ-023 ALIGN: error -> SEARCH; each error-free vsync rise increments count; count reaching LOCK_FRAMES -> LOCKED.
REQ-024 LOCKED: locked=1; any error -> SEARCH with locked=0 next cycle.
REQ-025 SHALL pulse sync_err only in ALIGN or LOCKED; error and lock completion in same cycle: error wins, go to SEARCH.
REQ-026 SHALL pulse frame_start on vsync rise in any state.
REQ-027 SHALL not stall counters on error; col/row keep freewheeling and resync at next edges.

Reset
REQ-028 SHALL on reset set col=0, row=0, frame_start=0, locked=0, sync_err=0, state SEARCH, count 0, registered syncs 0.
REQ-029 SHALL, after reset mid-frame, reacquire without false sync_err (SEARCH ignores errors).

Configuration
REQ-030 SHALL, with VGA_SYNC_DECODER_STATS_EN defined, add output err_count (16 bits, saturating at 16'hFFFF) counting sync_err pulses, reset to 0.
REQ-031 SHALL, without VGA_SYNC_DECODER_STATS_EN, omit err_count port and its logic entirely.

Structure
REQ-032 SHALL take default timing constants (800/525/640/480) and FSM state enum from shared package vga_timing_pkg.
REQ-033 SHALL instantiate sub-module sync_edge_det (register plus rise/fall detect) once each for hsync and vsync.

Verification
REQ-034 Reset, then two clean 800x525 frames -> locked rises at 3rd vsync rise; sync_err never pulses.
REQ-035 Locked, one line of 799 clocks -> sync_err 1 pulse, locked=0, relock after 2 further clean frames.
REQ-036 Locked, vsync held high 481 lines -> sync_err at vsync fall (row=481), state SEARCH.
REQ-037 Reset asserted at row 200 col 300 -> all outputs 0 immediately; no sync_err before lock.
REQ-038 Clean frames -> frame_start pulses every 420000 clocks with col=0, row=0 same cycle.
REQ-039 With VGA_SYNC_DECODER_STATS_EN, 3 injected errors spaced by relock -> err_count=3.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the sync-decoder lock FSM state encoding.
package vga_timing_pkg;

  localparam int unsigned DEF_TOTAL_COLS  = 800;
  localparam int unsigned DEF_TOTAL_ROWS  = 525;
  localparam int unsigned DEF_ACTIVE_COLS = 640;
  localparam int unsigned DEF_ACTIVE_ROWS = 480;
  localparam int unsigned DEF_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync input and reports its next-cycle rise/fall one edge early,
// so the consumer can load registered outputs that line up with the detected edge.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic sync_q;
  logic armed_q;

  // armed_q masks the first sample after reset so a sync that is already high
  // when reset releases mid-frame is not mistaken for a fresh edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_c_o = armed_q &  sync_i & ~sync_q;
  assign fall_c_o = armed_q & ~sync_i &  sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers col/row from hsync/vsync, checks line/frame timing and tracks lock.
// Optional err_count output is enabled by defining VGA_SYNC_DECODER_STATS_EN.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          hsync,
  input  logic                          vsync,
  output logic [$clog2(TOTAL_COLS)-1:0] col,
  output logic [$clog2(TOTAL_ROWS)-1:0] row,
  output logic                          frame_start,
  output logic                          locked,
  output logic                          sync_err
`ifdef VGA_SYNC_DECODER_STATS_EN
  ,
  output logic [15:0]                   err_count
`endif
);

  localparam int unsigned CW = $clog2(TOTAL_COLS);
  localparam int unsigned RW = $clog2(TOTAL_ROWS);
  localparam int unsigned NW = $clog2(LOCK_FRAMES + 1);

  localparam logic [CW-1:0] COL_LAST     = CW'(TOTAL_COLS - 1);
  localparam logic [CW-1:0] COL_ACT_LAST = CW'(ACTIVE_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(TOTAL_ROWS - 1);
  localparam logic [RW-1:0] ROW_ACT_END  = RW'(ACTIVE_ROWS);
  localparam logic [NW-1:0] CNT_LOCK     = NW'(LOCK_FRAMES);

  logic h_rise, h_fall, v_rise, v_fall;

  sync_edge_det u_hs_det (
    .clk_i    (clock),
    .rst_i    (reset),
    .sync_i   (hsync),
    .rise_c_o (h_rise),
    .fall_c_o (h_fall)
  );

  sync_edge_det u_vs_det (
    .clk_i    (clock),
    .rst_i    (reset),
    .sync_i   (vsync),
    .rise_c_o (v_rise),
    .fall_c_o (v_fall)
  );

  sync_state_e   state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          frame_start_q, frame_start_d;
  logic          locked_q, locked_d;
  logic          sync_err_q, sync_err_d;
  logic          line_err, frame_err, err;

  // Counters, timing checks and lock FSM next-state.
  always_comb begin
    col_d         = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    row_d         = row_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    if (h_rise) begin
      col_d = '0;
      row_d = (v_rise || row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    end

    line_err  = (h_rise && col_q != COL_LAST) ||
                (!h_rise && col_q == COL_LAST) ||
                (h_fall && col_q != COL_ACT_LAST);
    frame_err = (v_rise && (row_q != ROW_LAST || !h_rise)) ||
                (v_fall && row_d != ROW_ACT_END);
    err       = line_err | frame_err;

    case (state_q)
      ST_SEARCH: begin
        if (v_rise) begin
          state_d = ST_ALIGN;
          cnt_d   = '0;
        end
      end
      ST_ALIGN: begin
        if (err) begin
          state_d = ST_SEARCH;
        end else if (v_rise) begin
          cnt_d = cnt_q + NW'(1);
          if (cnt_d == CNT_LOCK) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (err) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase

    sync_err_d    = err && (state_q != ST_SEARCH);
    locked_d      = (state_d == ST_LOCKED);
    frame_start_d = v_rise;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [15:0] err_count_q;

  // Saturating count of reported sync errors.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (sync_err_d && err_count_q != 16'hFFFF) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (16x10, 10x6 active).
module tb_vga_sync_decoder;

  localparam int C  = 16;
  localparam int R  = 10;
  localparam int AC = 10;
  localparam int AR = 6;
  localparam int LF = 2;
  localparam int CW = $clog2(C);
  localparam int RW = $clog2(R);

  logic          clock;
  logic          reset;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          frame_start;
  logic          locked;
  logic          sync_err;
`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [15:0]   err_count;
`endif

  int total;
  int bad;
  int cyc;
  int fs_count;
  int fs_last_cyc;
  int fs_prev_cyc;
  int err_pulses;
  int lock_rise_fs;
  int base;
  logic [RW-1:0] err_row;
  logic          err_locked;
  logic          locked_prev;

  vga_sync_decoder #(
    .TOTAL_COLS  (C),
    .TOTAL_ROWS  (R),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR),
    .LOCK_FRAMES (LF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .col         (col),
    .row         (row),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err)
`ifdef VGA_SYNC_DECODER_STATS_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive at negedge, observe 1 time unit after the posedge.
  task automatic tick(input logic h, input logic v);
    @(negedge clock);
    hsync = h;
    vsync = v;
    @(posedge clock);
    #1;
    cyc++;
    if (frame_start) begin
      fs_count++;
      chk("fs_col", 32'(col), 32'd0);
      chk("fs_row", 32'(row), 32'd0);
      fs_prev_cyc = fs_last_cyc;
      fs_last_cyc = cyc;
    end
    if (sync_err) begin
      err_pulses++;
      err_row    = row;
      err_locked = locked;
    end
    if (locked && !locked_prev) lock_rise_fs = fs_count;
    locked_prev = locked;
  endtask

  task automatic frame(input int act_rows, input int short_row);
    int len;
    for (int r = 0; r < R; r++) begin
      len = (r == short_row) ? C - 1 : C;
      for (int c = 0; c < len; c++) tick(c < AC, r < act_rows);
    end
  endtask

  task automatic span(input int from, input int to);
    for (int i = from; i < to; i++) tick((i % C) < AC, (i / C) < AR);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; fs_count = 0; fs_last_cyc = 0; fs_prev_cyc = 0;
    err_pulses = 0; lock_rise_fs = -1; base = 0; err_row = '0; err_locked = 1'b0;
    locked_prev = 1'b0;
    reset = 1'b1; hsync = 1'b0; vsync = 1'b0;

    repeat (3) tick(1'b0, 1'b0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(sync_err), 32'd0);
    reset = 1'b0;
    repeat (4) tick(1'b0, 1'b0);

    // Two clean frames after the first vsync rise: lock at the third rise.
    repeat (3) frame(AR, -1);
    chk("lock_fs", 32'(lock_rise_fs), 32'd3);
    chk("locked_clean", 32'(locked), 32'd1);
    chk("clean_no_err", 32'(err_pulses), 32'd0);
    chk("fs_count", 32'(fs_count), 32'd3);
    chk("fs_period", 32'(fs_last_cyc - fs_prev_cyc), 32'(C * R));

    // One short line while locked.
    frame(AR, 3);
    chk("short_err", 32'(err_pulses), 32'd1);
    chk("short_unlock", 32'(locked), 32'd0);
    frame(AR, -1);
    frame(AR, -1);
    chk("not_yet_locked", 32'(locked), 32'd0);
    frame(AR, -1);
    chk("relock_fs", 32'(lock_rise_fs), 32'd7);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_one_err", 32'(err_pulses), 32'd1);
    chk("fs_period2", 32'(fs_last_cyc - fs_prev_cyc), 32'(C * R));

    // vsync held one line too long.
    frame(AR + 1, -1);
    chk("longvs_err", 32'(err_pulses), 32'd2);
    chk("longvs_row", 32'(err_row), 32'(AR + 1));
    chk("longvs_lockbit", 32'(err_locked), 32'd0);
    chk("longvs_unlock", 32'(locked), 32'd0);
    repeat (3) frame(AR, -1);
    chk("relock2_fs", 32'(lock_rise_fs), 32'd11);
    chk("relock2", 32'(locked), 32'd1);

    // Asynchronous reset mid-frame, then reacquire.
    span(0, 5 * C + 5);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_col", 32'(col), 32'd4);
    chk("pre_rst_row", 32'(row), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("arst_col", 32'(col), 32'd0);
    chk("arst_row", 32'(row), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_fs", 32'(frame_start), 32'd0);
    chk("arst_err", 32'(sync_err), 32'd0);
    span(5 * C + 5, 5 * C + 7);
    reset = 1'b0;
    base = err_pulses;
    span(5 * C + 7, R * C);
    repeat (3) frame(AR, -1);
    chk("reacq_no_err", 32'(err_pulses), 32'(base));
    chk("reacq_fs", 32'(lock_rise_fs), 32'd15);
    chk("reacq_locked", 32'(locked), 32'd1);

    // Three errors, each followed by a full relock.
    repeat (3) begin
      frame(AR, 3);
      repeat (3) frame(AR, -1);
    end
    chk("inj_errs", 32'(err_pulses), 32'(base + 3));
    chk("inj_lock_fs", 32'(lock_rise_fs), 32'd27);
    chk("inj_locked", 32'(locked), 32'd1);
`ifdef VGA_SYNC_DECODER_STATS_EN
    chk("err_count", 32'(err_count), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
